bus_arbiter: RTL and testbench

Data-bus arbiter for the MiniRISC system. It is the responder side of the `bus_req`/`bus_grant` handshake driven by the CPU control unit. It also serves the other bus masters (debug module, DMA).
- Grants exclusive ownership of the shared data-memory/peripheral bus to one master at a time.
- Holds the grant for as long as that master keeps its request asserted.
- Reports the current owner so the bus multiplexer can select that master's address, data and strobe lines.

---
 rtl/bus_arbiter_pkg.sv | 21 ++
 rtl/bus_arbiter_rr_pick.sv | 35 +++
 rtl/bus_arbiter.sv | 128 ++++++++++++
 tb/tb_bus_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the MiniRISC data-bus arbiter:
// FSM encoding, master indices and reset helpers.
package bus_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_e;

    localparam int MST_CPU = 0;
    localparam int MST_DBG = 1;
    localparam int MST_DMA = 2;

    localparam int HOLD_W = 16;

    // Reset value of last_owner, so the first search starts at index 0.
    function automatic int last_owner_rst(input int num_mst);
        return num_mst - 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester above
// i_last (with wrap-around), ignoring the fixed-priority master.
module rr_pick
    import bus_arbiter_pkg::*;
#(
    parameter  int NUM_MST = 3,
    localparam int IW      = $clog2(NUM_MST)
) (
    input  logic [NUM_MST-1:0] i_req,
    input  logic [NUM_MST-1:0] i_prio_mask,
    input  logic [IW-1:0]      i_last,
    output logic               o_valid,
    output logic [IW-1:0]      o_index
);

    logic [NUM_MST-1:0] w_req;

    assign w_req = i_req & ~i_prio_mask;

    // Walk the offsets downward so the nearest requester is written last.
    always_comb begin
        int j;
        o_valid = 1'b0;
        o_index = '0;
        j       = 0;
        for (int k = NUM_MST; k >= 1; k--) begin
            j = (int'(i_last) + k) % NUM_MST;
            if (w_req[j]) begin
                o_valid = 1'b1;
                o_index = IW'(j);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Data-bus arbiter: fixed-priority master plus round-robin for the
// rest, non-preemptive grants, hold-time watchdog status flag.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter  int NUM_MST  = 3,
    parameter  int PRIO_MST = 1,
    parameter  int MAX_HOLD = 255,
    localparam int IW       = $clog2(NUM_MST)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_MST-1:0] bus_req,
    output logic [NUM_MST-1:0] bus_grant,
    output logic [IW-1:0]      bus_owner,
    output logic               bus_busy,
    output logic               hold_timeout,
    input  logic               clr_status
);

    localparam logic [NUM_MST-1:0] ONE       = {{(NUM_MST-1){1'b0}}, 1'b1};
    localparam logic [NUM_MST-1:0] PRIO_MASK =
        (PRIO_MST < NUM_MST) ? (ONE << PRIO_MST) : '0;
    localparam logic [IW-1:0]      PRIO_IDX  = IW'(PRIO_MST);
    localparam logic [IW-1:0]      LAST_RST  = IW'(last_owner_rst(NUM_MST));
    localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(MAX_HOLD);

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    logic [IW-1:0]       r_owner;
    logic [IW-1:0]       w_owner_nxt;
    logic [IW-1:0]       r_last;
    logic [IW-1:0]       w_last_nxt;
    logic [NUM_MST-1:0]  r_grant;
    logic [NUM_MST-1:0]  w_grant_nxt;
    logic [HOLD_W-1:0]   r_cnt;
    logic [HOLD_W-1:0]   w_cnt_nxt;
    logic                r_timeout;
    logic                w_timeout_nxt;

    logic                w_prio_hit;
    logic                w_rr_valid;
    logic [IW-1:0]       w_rr_idx;
    logic                w_own_req;
    logic                w_other_req;

    rr_pick #(
        .NUM_MST (NUM_MST)
    ) u_rr_pick (
        .i_req       (bus_req),
        .i_prio_mask (PRIO_MASK),
        .i_last      (r_last),
        .o_valid     (w_rr_valid),
        .o_index     (w_rr_idx)
    );

    assign w_prio_hit  = |(bus_req & PRIO_MASK);
    assign w_own_req   = |(bus_req & r_grant);
    assign w_other_req = |(bus_req & ~r_grant);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ARB_IDLE;
            r_owner   <= '0;
            r_last    <= LAST_RST;
            r_grant   <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_last    <= w_last_nxt;
            r_grant   <= w_grant_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ARB_IDLE: begin
                if (w_prio_hit || w_rr_valid)
                    w_state_nxt = ARB_OWNED;
            end
            ARB_OWNED: begin
                if (!w_own_req)
                    w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs; set beats clear on the flag.
    always_comb begin
        w_owner_nxt   = r_owner;
        w_last_nxt    = r_last;
        w_grant_nxt   = r_grant;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = r_timeout & ~clr_status;
        unique case (r_state)
            ARB_IDLE: begin
                w_cnt_nxt = '0;
                if (w_prio_hit) begin
                    w_owner_nxt = PRIO_IDX;
                    w_grant_nxt = PRIO_MASK;
                end else if (w_rr_valid) begin
                    w_owner_nxt = w_rr_idx;
                    w_last_nxt  = w_rr_idx;
                    w_grant_nxt = ONE << w_rr_idx;
                end
            end
            ARB_OWNED: begin
                if (r_cnt != '1)
                    w_cnt_nxt = r_cnt + HOLD_W'(1);
                if (r_cnt == HOLD_MAX && w_other_req)
                    w_timeout_nxt = 1'b1;
                if (!w_own_req)
                    w_grant_nxt = '0;
            end
        endcase
    end

    assign bus_grant    = r_grant;
    assign bus_owner    = r_owner;
    assign bus_busy     = (r_state == ARB_OWNED);
    assign hold_timeout = r_timeout;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed scenarios followed by
// random request traffic, checked against a cycle-level reference model.
module tb_bus_arbiter;

    localparam int N    = 3;
    localparam int PRIO = 1;
    localparam int MAXH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] bus_req = '0;
    logic       clr_status = 1'b0;
    logic [2:0] bus_grant;
    logic [1:0] bus_owner;
    logic       bus_busy;
    logic       hold_timeout;

    bus_arbiter #(
        .NUM_MST  (N),
        .PRIO_MST (PRIO),
        .MAX_HOLD (MAXH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus_req      (bus_req),
        .bus_grant    (bus_grant),
        .bus_owner    (bus_owner),
        .bus_busy     (bus_busy),
        .hold_timeout (hold_timeout),
        .clr_status   (clr_status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] grant;
        logic [1:0] owner;
        logic       busy;
        logic       tmo;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: owner is -1 when the bus is free.
    int   m_owner = -1;
    int   m_last  = N - 1;
    int   m_cnt   = 0;
    bit   m_tmo   = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_step(input logic [2:0] req, input logic clr,
                                       input logic r);
        exp_t e;
        bit   set;
        if (r) begin
            m_owner = -1;
            m_last  = N - 1;
            m_cnt   = 0;
            m_tmo   = 1'b0;
        end else if (m_owner >= 0) begin
            set   = (m_cnt == MAXH) && ((req & ~(3'b001 << m_owner)) != 3'b000);
            m_tmo = set ? 1'b1 : (clr ? 1'b0 : m_tmo);
            if (m_cnt < 65535) m_cnt++;
            if (!req[m_owner]) m_owner = -1;
        end else begin
            if (clr) m_tmo = 1'b0;
            m_cnt = 0;
            if (req[PRIO]) begin
                m_owner = PRIO;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    int j;
                    j = (m_last + k) % N;
                    if (j != PRIO && req[j]) begin
                        m_owner = j;
                        m_last  = j;
                        break;
                    end
                end
            end
        end
        e.busy  = (m_owner >= 0);
        e.grant = e.busy ? (3'b001 << m_owner) : 3'b000;
        e.owner = e.busy ? 2'(m_owner) : 2'b00;
        e.tmo   = m_tmo;
        sb.push_back(e);
    endfunction

    // Monitor: one expected record per clock, compared mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("grant", 32'(bus_grant), 32'(e.grant));
            chk("busy", 32'(bus_busy), 32'(e.busy));
            chk("hold_timeout", 32'(hold_timeout), 32'(e.tmo));
            if (e.busy) chk("owner", 32'(bus_owner), 32'(e.owner));
        end
    end

    task automatic step(input logic [2:0] req, input logic clr = 1'b0,
                        input logic r = 1'b0);
        @(negedge clk);
        #1;
        rst        = r;
        bus_req    = req;
        clr_status = clr;
        model_step(req, clr, r);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("async_reset_grant", 32'(bus_grant), 32'd0);
        chk("async_reset_busy", 32'(bus_busy), 32'd0);
        model_step(bus_req, 1'b0, 1'b1);
    endtask

    initial begin
        logic [2:0] req;

        step(3'b000, 1'b0, 1'b1);
        step(3'b000, 1'b0, 1'b1);

        // single request and release
        step(3'b001);
        step(3'b001);
        step(3'b000);
        step(3'b000);

        // fixed priority, then round-robin among the rest
        step(3'b000, 1'b0, 1'b1);
        step(3'b111);
        step(3'b111);
        step(3'b101);
        step(3'b101);
        step(3'b101);
        step(3'b100);
        step(3'b100);
        step(3'b100);
        step(3'b000);

        // masters 0 and 2 contend, each holding for four cycles
        step(3'b000, 1'b0, 1'b1);
        for (int t = 0; t < 30; t++) begin
            req = 3'b101;
            if (m_owner >= 0 && m_cnt >= 3) req[m_owner] = 1'b0;
            step(req);
        end
        step(3'b000);

        // no preemption by the priority master
        step(3'b000, 1'b0, 1'b1);
        step(3'b001);
        step(3'b001);
        for (int t = 0; t < 4; t++) step(3'b011);
        step(3'b010);
        step(3'b010);
        step(3'b010);
        step(3'b000);

        // hold timeout: clear coincides with set, then a plain clear
        step(3'b000, 1'b0, 1'b1);
        step(3'b101);
        for (int k = 1; k <= 20; k++) step(3'b101, (k == 9) || (k == 15));
        step(3'b100);
        step(3'b100);
        step(3'b100);

        // async reset while master 2 owns the bus
        mid_reset();
        step(3'b101);
        step(3'b101);
        step(3'b000);
        step(3'b000);

        // random traffic
        req = 3'b000;
        for (int t = 0; t < 400; t++) begin
            req = req ^ 3'($urandom & $urandom);
            step(req, ($urandom_range(15) == 0));
        end
        step(3'b000);

        @(negedge clk);
        #2;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
